// File: rtl/program_sequencer_if.sv
// Program-memory read bus between the sequencer (master) and program memory (slave).
// A single req/ack handshake carries the address out and the instruction byte back.
interface program_sequencer_if;
    logic       pm_req;
    logic [7:0] pm_addr;
    logic       pm_ack;
    logic [7:0] pm_data;

    modport master (
        output pm_req,
        output pm_addr,
        input  pm_ack,
        input  pm_data
    );

    modport slave (
        input  pm_req,
        input  pm_addr,
        output pm_ack,
        output pm_data
    );
endinterface

// File: rtl/program_sequencer.sv
// Fetch/load/execute controller that owns the program counter, fetches over the
// pm req/ack bus, strobes the datapath once per instruction and resolves jumps.
module program_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    program_sequencer_if.master pm,
    input  logic                jmp,
    input  logic                jmp_nz,
    input  logic [3:0]          jump_nibble,
    input  logic                dont_jmp,
    input  logic                halt,
    output logic [7:0]          pc,
    output logic [7:0]          next_instr,
    output logic                instr_strobe,
    output logic                sync_reset,
    output logic                fetch_fault
);

    localparam logic [2:0] S_RESET_HOLD = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_LOAD       = 3'd2;
    localparam logic [2:0] S_EXEC       = 3'd3;
    localparam logic [2:0] S_HALTED     = 3'd4;
    localparam logic [2:0] S_FAULT      = 3'd5;

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [2:0]      state_reg, state_next;
    logic [7:0]      pc_reg, pc_next;
    logic [7:0]      instr_reg, instr_next;
    logic            hold_reg, hold_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            fault_reg, fault_next;
    logic            timeout_hit;
    logic            jump_taken;
    logic [7:0]      jump_target;

    // The count reaches TIMEOUT on this edge when it currently holds TIMEOUT-1.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign timeout_hit = (to_cnt_reg == TO_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end
    endgenerate

    assign jump_taken  = jmp | (jmp_nz & ~dont_jmp);
    assign jump_target = {jump_nibble, 4'h0};

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        hold_next   = hold_reg;
        to_cnt_next = to_cnt_reg;
        fault_next  = fault_reg;

        case (state_reg)
            S_RESET_HOLD: begin
                // Second edge after release leaves the hold state.
                hold_next = 1'b1;
                if (hold_reg) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                if (pm.pm_ack) begin
                    instr_next  = pm.pm_data;
                    to_cnt_next = '0;
                    state_next  = S_LOAD;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                    if (timeout_hit) begin
                        fault_next = 1'b1;
                        state_next = S_FAULT;
                    end
                end
            end

            S_LOAD: begin
                state_next = S_EXEC;
            end

            S_EXEC: begin
                pc_next    = jump_taken ? jump_target : pc_reg + 8'd1;
                state_next = halt ? S_HALTED : S_FETCH;
            end

            S_HALTED: begin
                if (!halt) begin
                    state_next = S_FETCH;
                end
            end

            S_FAULT: begin
                state_next = S_FAULT;
            end

            default: begin
                // Unreachable encodings re-run the decoder reset sequence.
                hold_next  = 1'b0;
                state_next = S_RESET_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= S_RESET_HOLD;
            pc_reg     <= 8'h00;
            instr_reg  <= 8'h00;
            hold_reg   <= 1'b0;
            to_cnt_reg <= '0;
            fault_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            hold_reg   <= hold_next;
            to_cnt_reg <= to_cnt_next;
            fault_reg  <= fault_next;
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign pm.pm_req    = (state_reg == S_FETCH);
    assign pm.pm_addr   = pc_reg;
    assign pc           = pc_reg;
    assign next_instr   = instr_reg;
    assign instr_strobe = (state_reg == S_EXEC);
    assign sync_reset   = (state_reg == S_RESET_HOLD);
    assign fetch_fault  = fault_reg;

endmodule

// File: tb/tb_program_sequencer.sv
// Randomised self-checking bench for program_sequencer: a transaction-level model
// predicts pc, fetched word and instruction period; a second instance checks timeout.
module tb_program_sequencer;

    logic       clk;
    logic       reset_n;
    logic       jmp, jmp_nz, dont_jmp, halt;
    logic [3:0] jump_nibble;
    logic [7:0] pc, next_instr;
    logic       instr_strobe, sync_reset, fetch_fault;
    logic [7:0] pc_to, next_instr_to;
    logic       strobe_to, sync_to, fault_to;

    program_sequencer_if bus ();
    program_sequencer_if bus_to ();

    program_sequencer #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pm           (bus.master),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jump_nibble  (jump_nibble),
        .dont_jmp     (dont_jmp),
        .halt         (halt),
        .pc           (pc),
        .next_instr   (next_instr),
        .instr_strobe (instr_strobe),
        .sync_reset   (sync_reset),
        .fetch_fault  (fetch_fault)
    );

    program_sequencer #(.TIMEOUT(4)) dut_to (
        .clk          (clk),
        .reset_n      (reset_n),
        .pm           (bus_to.master),
        .jmp          (jmp),
        .jmp_nz       (jmp_nz),
        .jump_nibble  (jump_nibble),
        .dont_jmp     (dont_jmp),
        .halt         (halt),
        .pc           (pc_to),
        .next_instr   (next_instr_to),
        .instr_strobe (strobe_to),
        .sync_reset   (sync_to),
        .fetch_fault  (fault_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int last_cyc = 0;
    int last_valid = 0;
    int pending_halt = 0;
    int n_instr = 0;
    logic [7:0] exp_pc;
    logic [7:0] exp_instr;
    logic prev_strobe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Global output invariants, only meaningful once reset is released.
    always @(negedge clk) begin
        if (reset_n) begin
            check("strobe_and_sync", 32'(instr_strobe & sync_reset), 32'd0);
            check("strobe_twice", 32'(instr_strobe & prev_strobe), 32'd0);
        end
        prev_strobe = instr_strobe;
    end

    // Called at a negedge with reset_n low; leaves the bench at the first FETCH negedge.
    task automatic release_reset();
        reset_n = 1'b1;
        exp_pc = 8'h00;
        exp_instr = 8'h00;
        last_valid = 0;
        pending_halt = 0;
        @(negedge clk);
        check("hold1_sync", 32'(sync_reset), 32'd1);
        check("hold1_req", 32'(bus.pm_req), 32'd0);
        @(negedge clk);
        check("hold2_sync", 32'(sync_reset), 32'd0);
        check("hold2_req", 32'(bus.pm_req), 32'd1);
        check("hold2_pc", 32'(pc), 32'd0);
    endtask

    task automatic check_reset_values();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_instr", 32'(next_instr), 32'd0);
        check("rst_req", 32'(bus.pm_req), 32'd0);
        check("rst_strobe", 32'(instr_strobe), 32'd0);
        check("rst_sync", 32'(sync_reset), 32'd1);
        check("rst_fault", 32'(fetch_fault), 32'd0);
        check("rst_to_fault", 32'(fault_to), 32'd0);
    endtask

    // One instruction from the first FETCH negedge to the next FETCH negedge.
    task automatic run_instr(input int waits, input logic [7:0] data, input logic j,
                             input logic jnz, input logic dz, input logic [3:0] nib,
                             input logic h, input int hc);
        logic [7:0] start_pc;
        logic       taken;
        start_pc = exp_pc;
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", 32'(bus.pm_req), 32'd1);
            check("fetch_addr", 32'(bus.pm_addr), 32'(exp_pc));
            check("fetch_pc", 32'(pc), 32'(exp_pc));
            check("fetch_strobe", 32'(instr_strobe), 32'd0);
            check("fetch_instr_hold", 32'(next_instr), 32'(exp_instr));
            bus.pm_ack  = (i == waits);
            bus.pm_data = (i == waits) ? data : 8'($urandom);
            halt        = h ? 1'b1 : 1'($urandom_range(0, 1));
            jmp         = 1'($urandom_range(0, 1));
            jmp_nz      = 1'($urandom_range(0, 1));
            dont_jmp    = 1'($urandom_range(0, 1));
            jump_nibble = 4'($urandom);
            @(negedge clk);
        end
        exp_instr = data;
        check("load_req", 32'(bus.pm_req), 32'd0);
        check("load_instr", 32'(next_instr), 32'(data));
        check("load_strobe", 32'(instr_strobe), 32'd0);
        bus.pm_ack  = 1'($urandom_range(0, 1));
        bus.pm_data = 8'($urandom);
        jmp = j; jmp_nz = jnz; dont_jmp = dz; jump_nibble = nib;
        halt = h ? 1'b1 : 1'($urandom_range(0, 1));
        @(negedge clk);
        check("exec_strobe", 32'(instr_strobe), 32'd1);
        check("exec_instr", 32'(next_instr), 32'(data));
        check("exec_req", 32'(bus.pm_req), 32'd0);
        check("exec_pc", 32'(pc), 32'(start_pc));
        if (last_valid != 0)
            check("period", 32'(cyc - last_cyc), 32'(waits + 3 + pending_halt));
        last_cyc = cyc;
        last_valid = 1;
        taken = j || (jnz && !dz);
        exp_pc = taken ? 8'(32'(nib) * 16) : 8'((32'(start_pc) + 1) % 256);
        bus.pm_ack  = 1'($urandom_range(0, 1));
        bus.pm_data = 8'($urandom);
        halt = h;
        $display("instr %0d: pc=%02h data=%02h waits=%0d jmp=%0b jnz=%0b z=%0b nib=%h halt=%0b -> pc=%02h",
                 n_instr, start_pc, data, waits, j, jnz, dz, nib, h, exp_pc);
        n_instr++;
        @(negedge clk);
        pending_halt = 0;
        if (h) begin
            for (int c = 0; c < hc; c++) begin
                check("halt_req", 32'(bus.pm_req), 32'd0);
                check("halt_strobe", 32'(instr_strobe), 32'd0);
                check("halt_pc", 32'(pc), 32'(exp_pc));
                halt = (c < hc - 1);
                bus.pm_ack = 1'($urandom_range(0, 1));
                jmp = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            pending_halt = hc;
        end
    endtask

    task automatic run_plain(input logic [7:0] data);
        run_instr(0, data, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        jmp = 1'b0; jmp_nz = 1'b0; dont_jmp = 1'b0; halt = 1'b0; jump_nibble = 4'h0;
        bus.pm_ack = 1'b0; bus.pm_data = 8'h00;
        bus_to.pm_ack = 1'b0; bus_to.pm_data = 8'h00;
        #2 reset_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        release_reset();

        // TIMEOUT=4 instance never gets an ack; main instance just waits 4 extra cycles.
        check("to_fault_start", 32'(fault_to), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("to_fault", 32'(fault_to), 32'(i == 4));
            check("to_req", 32'(bus_to.pm_req), 32'(i != 4));
        end
        check("to_fault_pc", 32'(pc_to), 32'd0);
        check("main_no_fault", 32'(fetch_fault), 32'd0);

        run_plain(8'h01);
        run_plain(8'h12);
        run_plain(8'h23);
        run_plain(8'h34);
        run_plain(8'h45);
        check("pc_05", 32'(bus.pm_addr), 32'h05);
        run_instr(0, 8'h56, 1'b1, 1'b0, 1'b0, 4'hA, 1'b0, 0);
        check("jmp_A0", 32'(bus.pm_addr), 32'hA0);
        run_instr(0, 8'h67, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 0);
        for (int i = 0; i < 5; i++) run_plain(8'(i + 8'h70));
        check("pc_05b", 32'(bus.pm_addr), 32'h05);
        run_instr(0, 8'h78, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 0);
        check("jnz_not_taken", 32'(bus.pm_addr), 32'h06);
        run_instr(0, 8'h79, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0, 0);
        check("jnz_taken", 32'(bus.pm_addr), 32'hF0);
        for (int i = 0; i < 15; i++) run_plain(8'(i));
        check("pc_FF", 32'(bus.pm_addr), 32'hFF);
        run_plain(8'h9A);
        check("wrap_00", 32'(bus.pm_addr), 32'h00);
        run_instr(3, 8'hBC, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 0);
        check("slow_ack_no_fault", 32'(fetch_fault), 32'd0);
        run_instr(0, 8'hCD, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 0);
        check("jmp_and_jnz", 32'(bus.pm_addr), 32'h30);
        run_instr(0, 8'hDE, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 0);
        run_instr(1, 8'hEF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3);
        check("halt_resume_11", 32'(bus.pm_addr), 32'h11);
        run_plain(8'h11);

        for (int n = 0; n < 250; n++) begin
            run_instr($urandom_range(0, 4), 8'($urandom),
                      ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 4'($urandom),
                      ($urandom_range(0, 7) == 0), $urandom_range(1, 3));
        end

        // Mid-fetch asynchronous reset: pm_req must drop within the cycle.
        check("pre_rst_req", 32'(bus.pm_req), 32'd1);
        check("to_fault_sticky", 32'(fault_to), 32'd1);
        check("to_req_sticky", 32'(bus_to.pm_req), 32'd0);
        reset_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        release_reset();
        run_plain(8'h5A);
        check("restart_pc", 32'(bus.pm_addr), 32'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetch-and-sequence controller for the 8-bit microprocessor core. It owns the program counter and fetches each instruction from program memory over a req/ack handshake. It presents the instruction on `next_instr` to the instruction decoder and strobes the datapath for exactly one execute cycle per instruction. It resolves `jmp`/`jmp_nz` from the decoder and drives the decoder's `sync_reset` after a hard reset.

## Interface
- `TIMEOUT`, default 15: number of FETCH cycles without `pm_ack` before a fetch fault. 0 disables the timeout.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `jmp` input 1: unconditional jump flag from the decoder; valid in EXEC.
- `jmp_nz` input 1: conditional jump flag from the decoder; valid in EXEC.
- `jump_nibble` input 4: jump target high nibble (the decoder's `ir_nibble`); valid in EXEC.
- `dont_jmp` input 1: ALU zero flag. When 1, `jmp_nz` is not taken.
- `halt` input 1: request to freeze after the current instruction.
- `pm_ack` input 1: program-memory data valid.
- `pm_data` input 8: program-memory read data.
- `pm_req` output 1: program-memory read request.
- `pm_addr` output 8: program-memory address; always equals `pc`.
- `pc` output 8: program counter.
- `next_instr` output 8: registered instruction word to the decoder.
- `instr_strobe` output 1: one-cycle execute enable to datapath register enables.
- `sync_reset` output 1: reset to the decoder and datapath.
- `fetch_fault` output 1: sticky timeout indication.

## Operation
- States: RESET_HOLD, FETCH, LOAD, EXEC, HALTED, FAULT.
- `reset_n` low, any state, takes effect immediately:
  - State is RESET_HOLD.
  - `pc`=8'h00, `next_instr`=8'h00, `pm_req`=0, `instr_strobe`=0, `sync_reset`=1, `fetch_fault`=0.
  - Timeout count is 0.
- RESET_HOLD:
  - `sync_reset`=1 for exactly 2 rising edges after `reset_n` is released.
  - Then goes to FETCH.
- FETCH:
  - `pm_req`=1 and `pm_addr`=`pc`, both held stable until ack.
  - On an edge with `pm_ack`=1: latch `pm_data` into `next_instr`, clear the timeout count, go to LOAD.
  - On an edge without ack: increment the timeout count. If the count reaches `TIMEOUT` (and `TIMEOUT`≠0), set `fetch_fault`=1 and go to FAULT.
- LOAD:
  - `pm_req`=0.
  - Single wait cycle while the decoder registers `next_instr`.
  - Unconditionally goes to EXEC.
- EXEC:
  - `instr_strobe`=1 for this cycle only.
  - Samples `jmp`, `jmp_nz`, `dont_jmp`, `jump_nibble` and `halt`.
  - Next `pc` is `{jump_nibble,4'h0}` if `jmp`=1 or (`jmp_nz`=1 and `dont_jmp`=0).
  - Otherwise next `pc` is `pc`+1, modulo 256 (8'hFF wraps to 8'h00).
  - `jmp` and `jmp_nz` both high: jump taken; `jmp` has priority, and the target is the same either way.
  - Next state is HALTED if `halt`=1, else FETCH.
- HALTED:
  - `pm_req`=0, `instr_strobe`=0, `pc` held.
  - Returns to FETCH on the first edge with `halt`=0.
- FAULT:
  - `pm_req`=0, `fetch_fault`=1, `pc` holds the faulting address.
  - Exits only via `reset_n`.
- Boundary rules:
  - `pm_ack` outside FETCH is ignored and `pm_data` is not sampled.
  - `halt` during FETCH or LOAD does not abort the fetch; it is acted on only in EXEC.
  - Ack arriving on the same edge the timeout would be reached: the ack wins and there is no fault.
  - `reset_n` asserted mid-fetch drops `pm_req` asynchronously.
  - `next_instr` changes only on an accepted ack or on reset.

## Timing
- All registered outputs change on the rising edge of `clk`, except the asynchronous reset values.
- Zero-wait memory:
  - Ack sampled at edge k.
  - `next_instr` valid after edge k (LOAD).
  - EXEC cycle follows edge k+1.
  - New `pc`/`pm_addr` after edge k+2 (FETCH).
- Minimum instruction period is 3 cycles. Each wait cycle of `pm_ack` adds one cycle.
- With `TIMEOUT`=N, `fetch_fault` rises on the N-th consecutive ack-less FETCH edge.
- `instr_strobe` is never high for two consecutive cycles.
- `sync_reset` and `instr_strobe` are never both high.

## Test plan
- Reset then zero-wait ack, `pm_data` sequence 8'h01,8'h12,8'h23:
  - `sync_reset` high for 2 cycles after release.
  - `pm_addr` 00,01,02.
  - `instr_strobe` every 3rd cycle.
  - `next_instr` follows the data.
- `jmp`=1, `jump_nibble`=4'hA in EXEC at `pc`=8'h05 → next `pm_addr`=8'hA0. Same with `jmp_nz`=1, `dont_jmp`=1 → `pm_addr`=8'h06.
- `pc`=8'hFF without a jump → next `pm_addr`=8'h00.
- `pm_ack` delayed 3 cycles, `TIMEOUT`=15:
  - `pm_addr` stable and `pm_req` high for 4 cycles.
  - The instruction period becomes 6 cycles.
  - No fault.
- No ack with `TIMEOUT`=4 → `fetch_fault`=1 after the 4th FETCH edge and `pm_req`=0. It stays set until `reset_n` low, which clears it and restarts at 8'h00.
- Two further asynchronous cases:
  - `halt`=1 asserted during FETCH at `pc`=8'h10: one EXEC occurs, then HALTED with `pc`=8'h11. Releasing `halt` resumes a fetch at 8'h11.
  - `reset_n` pulsed low mid-FETCH: `pm_req` falls within the same cycle and `pc`=8'h00.
